// File: rtl/sine_period_detector.sv
// Period and peak-amplitude meter for a signed sinusoidal sample stream.
// Rising zero crossings are detected with symmetric hysteresis; one result per input cycle.
module sine_period_detector #(
    parameter int WIDTH     = 8,
    parameter int HYST      = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_sample,
    output logic [CNT_WIDTH-1:0]    period,
    output logic [WIDTH-2:0]        peak,
    output logic                    out_valid,
    output logic                    locked,
    output logic                    timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic signed [WIDTH-1:0] POS_TH   = WIDTH'(HYST);
    localparam logic signed [WIDTH-1:0] NEG_TH   = WIDTH'(-HYST);
    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-2:0]        MAG_ONE  = (WIDTH-1)'(1);
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE  = CNT_WIDTH'(1);
    // Largest count that may still be incremented into a representable period.
    localparam logic [CNT_WIDTH-1:0]    CNT_LIMIT = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-2:0]       peak_acc_reg, peak_acc_next;
    logic                   neg_seen_reg, neg_seen_next;
    logic [CNT_WIDTH-1:0]   period_reg, period_next;
    logic [WIDTH-2:0]       peak_reg, peak_next;
    logic                   locked_reg, locked_next;
    logic                   out_valid_reg, out_valid_next;
    logic                   timeout_reg, timeout_next;

    logic                   is_pos;
    logic                   is_neg;
    logic [WIDTH-2:0]       mag;
    logic [WIDTH-2:0]       peak_max;

    // Saturated |sample|: only the low bits are needed because the most negative
    // value is special-cased and every other magnitude fits in WIDTH-1 bits.
    always_comb begin
        if (in_sample == MOST_NEG) begin
            mag = '1;
        end else if (in_sample[WIDTH-1]) begin
            mag = ~in_sample[WIDTH-2:0] + MAG_ONE;
        end else begin
            mag = in_sample[WIDTH-2:0];
        end
    end

    assign is_pos   = (in_sample >= POS_TH);
    assign is_neg   = (in_sample <= NEG_TH);
    assign peak_max = (mag > peak_acc_reg) ? mag : peak_acc_reg;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        peak_acc_next  = peak_acc_reg;
        neg_seen_next  = neg_seen_reg;
        period_next    = period_reg;
        peak_next      = peak_reg;
        locked_next    = locked_reg;
        out_valid_next = 1'b0;
        timeout_next   = 1'b0;

        if (in_valid) begin
            unique case (state_reg)
                IDLE: begin
                    if (is_neg) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (is_pos) begin
                        state_next    = RUN;
                        cnt_next      = '0;
                        peak_acc_next = mag;
                        neg_seen_next = 1'b0;
                    end
                end
                RUN: begin
                    if (is_pos && neg_seen_reg) begin
                        period_next    = cnt_reg + CNT_ONE;
                        peak_next      = peak_max;
                        out_valid_next = 1'b1;
                        locked_next    = 1'b1;
                        cnt_next       = '0;
                        neg_seen_next  = 1'b0;
                        peak_acc_next  = mag;
                    end else if (cnt_reg == CNT_LIMIT) begin
                        // No crossing within the counter range: drop lock and rearm.
                        timeout_next  = 1'b1;
                        locked_next   = 1'b0;
                        neg_seen_next = 1'b0;
                        cnt_next      = '0;
                        peak_acc_next = '0;
                        state_next    = IDLE;
                    end else begin
                        cnt_next      = cnt_reg + CNT_ONE;
                        peak_acc_next = peak_max;
                        if (is_neg) begin
                            neg_seen_next = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            peak_acc_reg  <= '0;
            neg_seen_reg  <= 1'b0;
            period_reg    <= '0;
            peak_reg      <= '0;
            locked_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            peak_acc_reg  <= peak_acc_next;
            neg_seen_reg  <= neg_seen_next;
            period_reg    <= period_next;
            peak_reg      <= peak_next;
            locked_reg    <= locked_next;
            out_valid_reg <= out_valid_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign period    = period_reg;
    assign peak      = peak_reg;
    assign locked    = locked_reg;
    assign out_valid = out_valid_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_sine_period_detector.sv
// Bench for sine_period_detector: directed waveforms plus random streams,
// each cycle compared against a sample-list reference model.
module tb_sine_period_detector;

    localparam int WIDTH = 8;
    localparam int HYST  = 8;
    localparam int CW    = 8;
    localparam int MAX_SAMPLES = (2 ** CW) - 1;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_sample;
    logic [CW-1:0]           period;
    logic [WIDTH-2:0]        peak;
    logic                    out_valid;
    logic                    locked;
    logic                    timeout;

    sine_period_detector #(
        .WIDTH     (WIDTH),
        .HYST      (HYST),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .period    (period),
        .peak      (peak),
        .out_valid (out_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 waits for a negative sample, 1 waits for the
    // first crossing, 2 measures. mags holds the magnitudes of every accepted
    // sample since (and including) the last crossing sample.
    int phase;
    bit neg_m;
    int mags[$];
    int exp_period, exp_peak;
    bit exp_locked, exp_ov, exp_to;
    int exp_to_count, obs_to_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int magnitude(input int s);
        if (s == -128) return 127;
        return (s < 0) ? -s : s;
    endfunction

    task automatic model_reset();
        phase = 0;
        neg_m = 1'b0;
        mags.delete();
        exp_period = 0;
        exp_peak   = 0;
        exp_locked = 1'b0;
        exp_ov     = 1'b0;
        exp_to     = 1'b0;
    endtask

    task automatic model_step(input bit v, input int s);
        int m;
        int pk;
        exp_ov = 1'b0;
        exp_to = 1'b0;
        if (!v) return;
        m = magnitude(s);
        case (phase)
            0: if (s <= -HYST) phase = 1;
            1: if (s >= HYST) begin
                phase = 2;
                neg_m = 1'b0;
                mags.delete();
                mags.push_back(m);
            end
            default: begin
                if (s >= HYST && neg_m) begin
                    pk = m;
                    foreach (mags[i]) if (mags[i] > pk) pk = mags[i];
                    exp_period = mags.size();
                    exp_peak   = pk;
                    exp_ov     = 1'b1;
                    exp_locked = 1'b1;
                    neg_m      = 1'b0;
                    mags.delete();
                    mags.push_back(m);
                end else if (mags.size() == MAX_SAMPLES) begin
                    exp_to     = 1'b1;
                    exp_locked = 1'b0;
                    neg_m      = 1'b0;
                    phase      = 0;
                    mags.delete();
                    exp_to_count++;
                end else begin
                    mags.push_back(m);
                    if (s <= -HYST) neg_m = 1'b1;
                end
            end
        endcase
    endtask

    task automatic step(input bit v, input int s);
        in_valid  = v;
        in_sample = s[WIDTH-1:0];
        @(posedge clk);
        #1;
        model_step(v, s);
        if (timeout === 1'b1) obs_to_count++;
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        check("timeout",   {31'd0, timeout},   {31'd0, exp_to});
        check("locked",    {31'd0, locked},    {31'd0, exp_locked});
        check("period",    {24'd0, period},    exp_period);
        check("peak",      {25'd0, peak},      exp_peak);
        if (exp_ov)
            $display("measure t=%0t period=%0d peak=%0d", $time, period, peak);
        if (exp_to)
            $display("timeout t=%0t locked=%0d", $time, locked);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_period"},    {24'd0, period},    0);
        check({tag, "_peak"},      {25'd0, peak},      0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 0);
        check({tag, "_locked"},    {31'd0, locked},    0);
        check({tag, "_timeout"},   {31'd0, timeout},   0);
    endtask

    // Asserts reset between clock edges and checks that outputs clear immediately.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_cleared(tag);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("reset %s t=%0t", tag, $time);
    endtask

    task automatic square(input int periods, input int amp, input bit gapped);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b1, (i < 5) ? -amp : amp);
                if (gapped) step(1'b0, int'($urandom_range(0, 255)) - 128);
            end
        end
    endtask

    initial begin
        int half, amp, sgn, s, hold;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        exp_to_count = 0;
        obs_to_count = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;

        // Square wave at full rate, then with gaps.
        square(6, 20, 1'b0);
        async_reset("pre_gap");
        square(6, 20, 1'b1);

        // Just inside hysteresis: never arms.
        async_reset("pre_hyst");
        for (int i = 0; i < 40; i++) step(1'b1, (i % 2 == 0) ? 7 : -7);
        // Exactly on the thresholds.
        for (int i = 0; i < 20; i++) step(1'b1, (i % 2 == 0) ? -8 : 8);

        // Saturating magnitude inside one period.
        async_reset("pre_sat");
        square(2, 20, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, (i == 2) ? -128 : ((i < 5) ? -20 : 20));
        square(3, 20, 1'b0);

        // Counter timeout, then recovery.
        async_reset("pre_timeout");
        square(3, 20, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 20);
        square(4, 20, 1'b0);

        // Sine approximating the oscillator, reset mid-run.
        for (int i = 0; i < 1300; i++) begin
            step(1'b1, $rtoi(115.0 * $sin(6.283185307 * i / 402.0)));
            if (i == 600) async_reset("mid_sine");
        end

        // Random waveforms with random gaps, amplitudes and occasional long holds.
        async_reset("pre_random");
        sgn = 1;
        for (int seg = 0; seg < 160; seg++) begin
            half = ($urandom_range(0, 19) == 0) ? int'($urandom_range(200, 300))
                                                : int'($urandom_range(1, 25));
            amp = int'($urandom_range(0, 128));
            sgn = -sgn;
            for (int i = 0; i < half; i++) begin
                hold = int'($urandom_range(0, amp));
                s = (sgn > 0) ? ((hold > 127) ? 127 : hold) : -hold;
                if ($urandom_range(0, 15) == 0) s = int'($urandom_range(0, 255)) - 128;
                step($urandom_range(0, 3) != 0, s);
            end
            if (seg == 80) async_reset("mid_random");
        end

        check("timeout_count", obs_to_count, exp_to_count);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
